poly_use_hint_stream: RTL and testbench
=======================================

POLY_USE_HINT_STREAM -- requirements
Module: poly_use_hint_stream

Interface
REQ-001 Parameter LANES, default 4: coefficients per beat; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 Parameter OMEGA, default 80: maximum legal hint weight per polynomial.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block accepts the beat this cycle.
REQ-007 in_coef  input  32*LANES  coefficients; lane k at bits [32k+31:32k]; each value in 0..Q-1.
REQ-008 in_hint  input  LANES  hint bit per lane.
REQ-009 in_mode  input  1  0 selects GAMMA2=95232 (m=44); 1 selects GAMMA2=261888 (m=16).
REQ-010 out_valid  output  1  output beat valid.
REQ-011 out_ready  input  1  downstream accepts the output beat.
REQ-012 out_coef  output  32*LANES  corrected high bits a1, zero-extended, with the same lane order.
REQ-013 out_last  output  1  final beat of the polynomial.
REQ-014 out_hint_cnt  output  9  total hint weight of the polynomial; valid when out_last=1, 0 otherwise.
REQ-015 out_hint_err  output  1  out_hint_cnt > OMEGA; valid when out_last=1, 0 otherwise.

Function
REQ-016 One polynomial is 256 coefficients, transferred as BEATS=256/LANES beats.
REQ-017 A transfer occurs when valid and ready are both high on a clock edge.
REQ-018 in_mode is sampled on beat 0 and held for the whole polynomial; changes on later beats are ignored.
REQ-019 The beat counter runs 0..BEATS-1, increments per accepted input beat, and wraps to 0 after BEATS-1; polynomials stream back-to-back with no idle cycle.
REQ-020 Decompose, mode 0: t=(a+127)>>7; a1=(t*11275+2^23)>>24; if a1>43 then a1=0.
REQ-021 Decompose, mode 1: t=(a+127)>>7; a1=((t*1025+2^21)>>22) & 15.
REQ-022 Low part: a0=a-2*GAMMA2*a1; if a0>(Q-1)/2 then a0=a0-Q; Q=8380417.
REQ-023 Correction with hint=0: output a1.
REQ-024 Correction with hint=1 and a0>0: output (a1+1) mod m.
REQ-025 Correction with hint=1 and a0<=0: output (a1-1) mod m.
REQ-026 The datapath is a two-stage pipeline: stage 1 registers a1, a0, hint, mode and last; stage 2 registers the corrected value. Latency is 2 cycles from input transfer to out_valid.
REQ-027 Backpressure: when out_valid=1 and out_ready=0, both stages hold and in_ready=0.
REQ-028 Without backpressure, in_ready=1 and the block sustains 1 beat/cycle.
REQ-029 Output data is held stable while out_valid=1 and out_ready=0.
REQ-030 The hint counter adds popcount(in_hint) per accepted beat.
REQ-031 On the last beat, the final count travels with that beat to out_hint_cnt, and the accumulator restarts at 0 for the next polynomial in the same cycle.
REQ-032 out_hint_err is combinational from the registered count only.

Reset
REQ-033 On rst: out_valid=0, out_coef=0, out_last=0, out_hint_cnt=0, out_hint_err=0, beat counter=0, hint accumulator=0, all stage valids=0.
REQ-034 in_ready=0 during the reset cycle and 1 in the cycle after.
REQ-035 Reset mid-polynomial discards all partial beats; the next accepted beat is beat 0.
REQ-036 rst has priority over any simultaneous transfer.

Structure
REQ-037 Shared package dilithium_pkg holds Q, GAMMA2_88=95232, GAMMA2_32=261888, the mode encoding and N=256.
REQ-038 Sub-module use_hint_lane: combinational decompose plus correction for one coefficient, with a mode input; it is instantiated LANES times.
REQ-039 The pipeline registers, beat counter and hint counter reside in the top level only.

Verification
REQ-040 Mode 0, LANES=4: a=100, h=0 -> 0; a=100, h=1 -> 1; a=0, h=1 -> 43; a=8380416, h=1 -> 43; a=8380416, h=0 -> 0.
REQ-041 Mode 1: a=300000, h=1 -> 0; a=300000, h=0 -> 1; a=8380416, h=1 -> 15; a=0, h=0 -> 0.
REQ-042 Full polynomial with 81 hint bits set, OMEGA=80 -> out_hint_cnt=81 and out_hint_err=1 on the beat-63 output only; with exactly 80 set -> err=0.
REQ-043 Random out_ready toggling over 3 back-to-back polynomials -> outputs match a reference model, no beat lost or duplicated, data stable while stalled, out_last every 64th beat.
REQ-044 rst asserted after beat 20 -> out_valid=0 next cycle; the following polynomial yields the correct hint count and out_last on its own beat 63.
REQ-045 in_mode toggled on beat 5 -> mode from beat 0 applied to all 64 beats.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants for the hint-correction stream: modulus, GAMMA2
// choices, mode encoding and the per-lane data types.
package dilithium_pkg;

  localparam int N         = 256;
  localparam int Q         = 8380417;
  localparam int GAMMA2_88 = 95232;
  localparam int GAMMA2_32 = 261888;

  // in_mode encoding: 0 -> GAMMA2_88 (m=44), 1 -> GAMMA2_32 (m=16)
  localparam logic MODE_88 = 1'b0;
  localparam logic MODE_32 = 1'b1;

  localparam logic signed [33:0] Q_S        = 34'(Q);
  localparam logic signed [33:0] HALF_Q_S   = 34'((Q - 1) / 2);
  localparam logic signed [33:0] TWO_G2_88  = 34'(2 * GAMMA2_88);
  localparam logic signed [33:0] TWO_G2_32  = 34'(2 * GAMMA2_32);

  typedef logic [5:0]         a1_t;
  typedef logic signed [33:0] a0_t;

  // Largest legal a1 value (m-1) for the given mode.
  function automatic a1_t a1_max(input logic mode);
    return (mode == MODE_32) ? 6'd15 : 6'd43;
  endfunction

endpackage

// File: rtl/use_hint_lane.sv
// One coefficient lane: decompose a into (a1, a0), and apply the hint to an
// already-registered (a1, a0) pair. Both halves are purely combinational.
module use_hint_lane
  import dilithium_pkg::*;
(
  input  logic [31:0] coef,
  input  logic        mode,
  output a1_t         a1,
  output a0_t         a0,
  input  a1_t         r_a1,
  input  a0_t         r_a0,
  input  logic        r_hint,
  input  logic        r_mode,
  output a1_t         corr
);

  logic [32:0]        t;
  logic [47:0]        p88;
  logic [47:0]        p32;
  logic signed [33:0] sub;
  logic signed [33:0] a0_raw;
  a1_t                top_val;

  always_comb begin
    t   = ({1'b0, coef} + 33'd127) >> 7;
    p88 = {15'd0, t} * 48'd11275 + 48'd8388608;
    p32 = {15'd0, t} * 48'd1025 + 48'd2097152;
    if (mode == MODE_32) begin
      a1 = {2'b00, 4'(p32 >> 22)};
    end else if ((p88 >> 24) > 48'd43) begin
      a1 = '0;
    end else begin
      a1 = 6'(p88 >> 24);
    end
    sub    = ((mode == MODE_32) ? TWO_G2_32 : TWO_G2_88) * $signed({28'd0, a1});
    a0_raw = $signed({2'b00, coef}) - sub;
    a0     = (a0_raw > HALF_Q_S) ? a0_raw - Q_S : a0_raw;
  end

  // Correction wraps modulo m in both directions.
  always_comb begin
    top_val = a1_max(r_mode);
    if (!r_hint) begin
      corr = r_a1;
    end else if (r_a0 > 34'sd0) begin
      corr = (r_a1 >= top_val) ? 6'd0 : r_a1 + 6'd1;
    end else begin
      corr = (r_a1 == 6'd0) ? top_val : r_a1 - 6'd1;
    end
  end

endmodule

// File: rtl/poly_use_hint_stream.sv
// Streaming UseHint over 256-coefficient polynomials, LANES coefficients per
// beat, two-stage pipeline with per-polynomial hint weight accounting.
module poly_use_hint_stream
  import dilithium_pkg::*;
#(
  parameter int LANES = 4,
  parameter int OMEGA = 80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*LANES-1:0]   in_coef,
  input  logic [LANES-1:0]      in_hint,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LANES-1:0]   out_coef,
  output logic                  out_last,
  output logic [8:0]            out_hint_cnt,
  output logic                  out_hint_err
);

  localparam int         BEATS     = N / LANES;
  localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);
  localparam logic [9:0] OMEGA_W   = 10'(OMEGA);

  // Handshake: a beat moves on any rising edge where valid && ready. Both
  // stages advance together; a stalled output beat freezes the whole pipe.
  logic       advance;
  logic       xfer;
  logic       is_last;
  logic       mode_cur;
  logic [7:0] beat_cnt;
  logic       mode_hold;
  logic [8:0] hint_acc;
  logic [8:0] hint_pop;
  logic [8:0] hint_total;

  logic       s1_valid;
  logic       s1_last;
  logic       s1_mode;
  logic [8:0] s1_cnt;
  logic [LANES-1:0] s1_hint;

  a1_t d_a1  [LANES];
  a0_t d_a0  [LANES];
  a1_t s1_a1 [LANES];
  a0_t s1_a0 [LANES];
  a1_t corr  [LANES];

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance && !rst;
  assign xfer     = in_valid && in_ready;
  assign is_last  = (beat_cnt == LAST_BEAT);
  // Mode is taken live on beat 0 and from the held copy afterwards.
  assign mode_cur = (beat_cnt == 8'd0) ? in_mode : mode_hold;
  assign hint_total = hint_acc + hint_pop;
  assign out_hint_err = ({1'b0, out_hint_cnt} > OMEGA_W);

  always_comb begin
    hint_pop = '0;
    for (int k = 0; k < LANES; k++) begin
      hint_pop = hint_pop + {8'd0, in_hint[k]};
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    use_hint_lane u_lane (
      .coef   (in_coef[32*g +: 32]),
      .mode   (mode_cur),
      .a1     (d_a1[g]),
      .a0     (d_a0[g]),
      .r_a1   (s1_a1[g]),
      .r_a0   (s1_a0[g]),
      .r_hint (s1_hint[g]),
      .r_mode (s1_mode),
      .corr   (corr[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt     <= '0;
      mode_hold    <= MODE_88;
      hint_acc     <= '0;
      s1_valid     <= 1'b0;
      s1_last      <= 1'b0;
      s1_mode      <= MODE_88;
      s1_cnt       <= '0;
      s1_hint      <= '0;
      out_valid    <= 1'b0;
      out_coef     <= '0;
      out_last     <= 1'b0;
      out_hint_cnt <= '0;
      for (int k = 0; k < LANES; k++) begin
        s1_a1[k] <= '0;
        s1_a0[k] <= '0;
      end
    end else begin
      if (xfer) begin
        beat_cnt <= is_last ? 8'd0 : 8'(beat_cnt + 8'd1);
        hint_acc <= is_last ? 9'd0 : hint_total;
        if (beat_cnt == 8'd0) begin
          mode_hold <= in_mode;
        end
      end
      if (advance) begin
        s1_valid <= xfer;
        s1_last  <= xfer && is_last;
        s1_cnt   <= (xfer && is_last) ? hint_total : 9'd0;
        s1_mode  <= mode_cur;
        s1_hint  <= in_hint;
        for (int k = 0; k < LANES; k++) begin
          s1_a1[k] <= d_a1[k];
          s1_a0[k] <= d_a0[k];
          out_coef[32*k +: 32] <= {26'd0, corr[k]};
        end
        out_valid    <= s1_valid;
        out_last     <= s1_valid && s1_last;
        out_hint_cnt <= (s1_valid && s1_last) ? s1_cnt : 9'd0;
      end
    end
  end

endmodule

// File: tb/tb_poly_use_hint_stream.sv
// Bench for poly_use_hint_stream: directed single-beat vectors, a stalled
// three-polynomial stream against a reference model, and a mid-poly reset.
module tb_poly_use_hint_stream;

  localparam int LANES = 4;
  localparam int Q     = 8380417;
  localparam int W     = 32*LANES + 11;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [32*LANES-1:0] in_coef;
  logic [LANES-1:0]    in_hint;
  logic                in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [32*LANES-1:0] out_coef;
  logic                out_last;
  logic [8:0]          out_hint_cnt;
  logic                out_hint_err;
  logic [W-1:0]        out_word;

  assign out_word = {out_coef, out_last, out_hint_cnt, out_hint_err};

  poly_use_hint_stream #(.LANES(LANES), .OMEGA(80)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_coef      (in_coef),
    .in_hint      (in_hint),
    .in_mode      (in_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_coef     (out_coef),
    .out_last     (out_last),
    .out_hint_cnt (out_hint_cnt),
    .out_hint_err (out_hint_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // stimulus store: 0..191 three polys, 192..212 partial poly, 213..276 final poly
  localparam int NSTIM = 277;
  logic [32*LANES-1:0] stim_coef [NSTIM];
  logic [LANES-1:0]    stim_hint [NSTIM];
  logic                stim_mode [NSTIM];

  // reference model state
  int   m_beat = 0;
  int   m_acc  = 0;
  logic m_mode = 1'b0;

  int         n_last = 0;
  logic [8:0] last_cnt [8];
  logic       last_err [8];

  typedef struct {
    logic [31:0] coef;
    logic        hint;
    logic        mode;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [31:0] ref_lane(input logic [31:0] a, input logic h, input logic md);
    longint t, a1, a0, m, g2;
    t = (longint'({32'd0, a}) + 127) >>> 7;
    if (!md) begin
      a1 = (t * 11275 + 8388608) >>> 24;
      if (a1 > 43) a1 = 0;
      m  = 44;
      g2 = 2 * 95232;
    end else begin
      a1 = ((t * 1025 + 2097152) >>> 22) & 15;
      m  = 16;
      g2 = 2 * 261888;
    end
    a0 = longint'({32'd0, a}) - g2 * a1;
    if (a0 > (Q - 1) / 2) a0 = a0 - Q;
    if (h) begin
      if (a0 > 0) a1 = (a1 + 1) % m;
      else        a1 = (a1 - 1 + m) % m;
    end
    return 32'(a1);
  endfunction

  task automatic push_expected(input logic [32*LANES-1:0] c, input logic [LANES-1:0] h, input logic md);
    logic [32*LANES-1:0] oc;
    logic                last;
    logic [8:0]          cnt;
    if (m_beat == 0) m_mode = md;
    for (int k = 0; k < LANES; k++) begin
      oc[32*k +: 32] = ref_lane(c[32*k +: 32], h[k], m_mode);
      m_acc += int'(h[k]);
    end
    last = (m_beat == 255 / LANES);
    cnt  = last ? 9'(m_acc) : 9'd0;
    exp_q.push_back({oc, last, cnt, last && (m_acc > 80)});
    if (last) begin
      m_acc  = 0;
      m_beat = 0;
    end else begin
      m_beat++;
    end
  endtask

  // driver + scoreboard: inputs change on the falling edge, transfers are
  // judged just after, ahead of the rising edge that commits them
  task automatic run_beats(input int first, input int count, input bit rand_ready, input bit drain);
    int           idx;
    int           cycles;
    int           budget;
    bit           stalled;
    logic [W-1:0] held;
    logic [W-1:0] exp;
    idx     = first;
    cycles  = 0;
    budget  = count * 20 + 100;
    stalled = 1'b0;
    held    = '0;
    while ((idx < first + count) || (drain && exp_q.size() > 0)) begin
      if (cycles >= budget) begin
        checks++; errors++;
        $display("FAIL timeout: %0d beats still expected after %0d cycles", exp_q.size(), cycles);
        break;
      end
      @(negedge clk);
      cycles++;
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (idx < first + count) begin
        in_valid = 1'b1;
        in_coef  = stim_coef[idx];
        in_hint  = stim_hint[idx];
        in_mode  = stim_mode[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_word !== held) begin
          errors++;
          $display("FAIL stall_hold: valid=%b word=%h required valid=1 word=%h", out_valid, out_word, held);
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_word;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h with nothing expected", out_word);
        end else begin
          exp = exp_q.pop_front();
          if (out_word !== exp) begin
            errors++;
            $display("FAIL stream_beat: got %h required %h", out_word, exp);
          end
        end
        if (out_last && n_last < 8) begin
          last_cnt[n_last] = out_hint_cnt;
          last_err[n_last] = out_hint_err;
          n_last++;
        end
      end
      if (in_valid && in_ready) begin
        push_expected(stim_coef[idx], stim_hint[idx], stim_mode[idx]);
        idx++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  initial begin
    int b;
    int base_mode;
    int wait_n;

    vecs[0] = '{32'd100,     1'b0, 1'b0, 32'd0};
    vecs[1] = '{32'd100,     1'b1, 1'b0, 32'd1};
    vecs[2] = '{32'd0,       1'b1, 1'b0, 32'd43};
    vecs[3] = '{32'd8380416, 1'b1, 1'b0, 32'd43};
    vecs[4] = '{32'd8380416, 1'b0, 1'b0, 32'd0};
    vecs[5] = '{32'd300000,  1'b1, 1'b1, 32'd0};
    vecs[6] = '{32'd300000,  1'b0, 1'b1, 32'd1};
    vecs[7] = '{32'd8380416, 1'b1, 1'b1, 32'd15};
    vecs[8] = '{32'd0,       1'b0, 1'b1, 32'd0};

    for (int i = 0; i < NSTIM; i++) begin
      b = (i < 213) ? (i % 64) : (i - 213);
      base_mode = (i < 64) ? 0 : (i < 128) ? 1 : (i < 192) ? 0 : (i < 213) ? 1 : 0;
      stim_mode[i] = 1'(base_mode) ^ (b >= 5);
      for (int k = 0; k < LANES; k++) begin
        stim_coef[i][32*k +: 32] = 32'($urandom_range(0, Q - 1));
        if (b == 1) stim_coef[i][32*k +: 32] = (k % 2 == 0) ? 32'd0 : 32'(Q - 1);
        if (i < 64)       stim_hint[i][k] = (b * 4 + k) < 81;
        else if (i < 128) stim_hint[i][k] = (b * 4 + k) >= 176;
        else if (i < 192) stim_hint[i][k] = ($urandom_range(0, 3) == 0);
        else if (i < 213) stim_hint[i][k] = 1'b1;
        else              stim_hint[i][k] = ((b * 4 + k) % 7) == 0;
      end
    end

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_coef   = '0;
    in_hint   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_bit("reset_in_ready", in_ready, 1'b0);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_out_last", out_last, 1'b0);
    check_bit("reset_out_err", out_hint_err, 1'b0);
    checks++;
    if (out_coef !== '0 || out_hint_cnt !== 9'd0) begin
      errors++;
      $display("FAIL reset_out_data: coef=%h cnt=%0d required 0", out_coef, out_hint_cnt);
    end
    rst = 1'b0;
    #1;
    check_bit("post_reset_in_ready", in_ready, 1'b1);

    // directed single-beat vectors
    for (int i = 0; i < 9; i++) begin
      do_reset();
      @(negedge clk);
      in_valid  = 1'b1;
      in_coef   = {LANES{vecs[i].coef}};
      in_hint   = {LANES{vecs[i].hint}};
      in_mode   = vecs[i].mode;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_n = 0;
      while (!out_valid && wait_n < 5) begin
        @(negedge clk);
        wait_n++;
      end
      checks++;
      if (!out_valid || wait_n != 1) begin
        errors++;
        $display("FAIL vec%0d_latency: valid=%b extra_cycles=%0d required valid=1 extra_cycles=1", i, out_valid, wait_n);
      end
      checks++;
      if (out_coef !== {LANES{vecs[i].exp}} || out_last !== 1'b0 || out_hint_cnt !== 9'd0) begin
        errors++;
        $display("FAIL vec%0d_value: coef=%h last=%b cnt=%0d required lanes=%0d last=0 cnt=0",
                 i, out_coef, out_last, out_hint_cnt, vecs[i].exp);
      end
    end

    // three back-to-back polynomials under random backpressure
    do_reset();
    exp_q.delete();
    m_beat = 0;
    m_acc  = 0;
    n_last = 0;
    run_beats(0, 192, 1'b1, 1'b1);
    checks++;
    if (n_last != 3) begin
      errors++;
      $display("FAIL last_count: got %0d required 3", n_last);
    end
    checks++;
    if (last_cnt[0] !== 9'd81 || last_err[0] !== 1'b1) begin
      errors++;
      $display("FAIL poly0_hint: cnt=%0d err=%b required cnt=81 err=1", last_cnt[0], last_err[0]);
    end
    checks++;
    if (last_cnt[1] !== 9'd80 || last_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL poly1_hint: cnt=%0d err=%b required cnt=80 err=0", last_cnt[1], last_err[1]);
    end

    // reset after beat 20 of a polynomial
    run_beats(192, 21, 1'b0, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_bit("midreset_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check_bit("midreset_out_valid", out_valid, 1'b0);
    check_bit("midreset_out_last", out_last, 1'b0);
    rst = 1'b0;
    #1;
    check_bit("midreset_ready_after", in_ready, 1'b1);
    exp_q.delete();
    m_beat = 0;
    m_acc  = 0;
    n_last = 0;
    run_beats(213, 64, 1'b1, 1'b1);
    checks++;
    if (n_last != 1 || last_cnt[0] !== 9'd37 || last_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_poly: lasts=%0d cnt=%0d err=%b required lasts=1 cnt=37 err=0",
               n_last, last_cnt[0], last_err[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
